sap_core: RTL and testbench
===========================

SAP_CORE -- requirements
Module: sap_core

Interface
REQ-001 Parameter DATA_W, default 8, data and bus width; legal values are DATA_W >= ADDR_W+4.
REQ-002 Parameter ADDR_W, default 4, RAM address width; RAM depth is 2^ADDR_W words.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 pr_mode  input  1  program mode; high halts execution and gives the RAM write port to the programmer.
REQ-006 pr_we  input  1  program write strobe; honoured only while pr_mode=1.
REQ-007 pr_address  input  ADDR_W  program write address.
REQ-008 pr_data  input  DATA_W  program write data.
REQ-009 out_data  output  DATA_W  output register contents.
REQ-010 out_valid  output  1  one-cycle pulse, high in the cycle after out_data is updated.
REQ-011 halted  output  1  high while the core is in the HALT state.
REQ-012 pc_dbg  output  ADDR_W  current program counter value.
REQ-013 step_dbg  output  3  current sequencer state encoding: FETCH0=0, FETCH1=1, EXEC0=2, EXEC1=3, EXEC2=4, HALT=7.

Function
REQ-014 Instruction word: opcode = bits [DATA_W-1:DATA_W-4]; operand = bits [ADDR_W-1:0]; all other bits are ignored.
REQ-015 RAM shall have a synchronous write and a combinational read; read address = MAR.
REQ-016 Sequencer states are FETCH0, FETCH1, EXEC0, EXEC1, EXEC2 and HALT, evaluated one state per clock.
REQ-017 FETCH0: MAR<=PC; next state FETCH1.
REQ-018 FETCH1: IR<=RAM[MAR], PC<=PC+1 modulo 2^ADDR_W (the maximum address wraps to 0); next state EXEC0.
REQ-019 Opcode 0x0 NOP: EXEC0 performs no operation, then FETCH0.
REQ-020 Opcode 0x1 LDA: EXEC0 MAR<=operand; EXEC1 A<=RAM[MAR]; then FETCH0.
REQ-021 Opcode 0x2 ADD: EXEC0 MAR<=operand; EXEC1 B<=RAM[MAR]; EXEC2 A<=A+B (low DATA_W bits), flags updated; then FETCH0.
REQ-022 Opcode 0x3 SUB: same sequence as ADD, computed as A+~B+1; C=1 means no borrow (A>=B unsigned).
REQ-023 Opcode 0x4 STA: EXEC0 MAR<=operand; EXEC1 RAM[MAR]<=A; then FETCH0.
REQ-024 Opcode 0x5 LDI: EXEC0 A<=operand zero-extended to DATA_W; then FETCH0.
REQ-025 Opcode 0x6 JMP: EXEC0 PC<=operand; then FETCH0.
REQ-026 Opcodes 0x7 JC and 0x8 JZ: EXEC0 PC<=operand if C (JC) or Z (JZ) is set, otherwise PC unchanged; then FETCH0.
REQ-027 Opcode 0xE OUT: EXEC0 OUT<=A; out_valid=1 in the following cycle only; then FETCH0.
REQ-028 Opcode 0xF HLT: EXEC0 moves to HALT; HALT holds all state until reset or pr_mode=1.
REQ-029 Undefined opcodes (0x9-0xD) shall execute as NOP.
REQ-030 Flags C and Z shall update only in the ADD/SUB EXEC2 cycle; C = carry out of bit DATA_W-1; Z = (result==0).
REQ-031 pr_mode=1, sampled on a clock edge, forces the sequencer to FETCH0 and PC to 0 and clears halted; A, B, OUT and the flags are retained.
REQ-032 pr_mode=1 and pr_we=1 in the same cycle write pr_data to RAM[pr_address]; a core STA write is suppressed while pr_mode=1.
REQ-033 pr_mode=1 asserted mid-instruction aborts that instruction with no further register or RAM side effects.
REQ-034 After pr_mode falls, the first FETCH0 occurs on the next rising edge, fetching from address 0.
REQ-035 pr_we while pr_mode=0 shall be ignored.

Reset
REQ-036 rst=0 asynchronously clears PC, MAR, IR, A, B, OUT, C and Z to 0, sets the sequencer to FETCH0, and drives out_valid=0, halted=0, step_dbg=0.
REQ-037 RAM contents shall not be affected by reset.
REQ-038 Release of rst is synchronous to clk; the first fetch occurs on the first rising edge with rst=1.

Verification
REQ-039 Program {LDA 14, ADD 15, OUT, HLT}, RAM[14]=28, RAM[15]=14 -> out_data=42 with one out_valid pulse; halted=1; C=0, Z=0.
REQ-040 LDI 5; STA 9; LDA 9; SUB 9; JZ 7; at address 7: OUT; HLT -> out_data=0, Z=1, C=1; the branch is taken.
REQ-041 DATA_W=8, A=0xF0, ADD of 0x20 -> A=0x10, C=1, Z=0; then JC 0 -> PC=0.
REQ-042 JMP 15 at address 15, ADDR_W=4 -> PC loops at 15; a NOP at 15 with no jump -> PC wraps to 0.
REQ-043 pr_mode pulsed high during EXEC1 of STA -> target RAM word unchanged, PC=0, restart at address 0.
REQ-044 rst=0 asserted mid-ADD -> all registers are 0 immediately without waiting for a clock edge, RAM is preserved, and the program reruns from address 0.

Source files
------------

// File: rtl/sap_core.sv
// SAP-style 8-bit accumulator core: internal RAM, six-state sequencer,
// ADD/SUB with carry and zero flags, and a programming port that halts the core.
module sap_core #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pr_mode,
    input  logic              pr_we,
    input  logic [ADDR_W-1:0] pr_address,
    input  logic [DATA_W-1:0] pr_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              halted,
    output logic [ADDR_W-1:0] pc_dbg,
    output logic [2:0]        step_dbg
);

    typedef enum logic [2:0] {
        StFetch0 = 3'd0,
        StFetch1 = 3'd1,
        StExec0  = 3'd2,
        StExec1  = 3'd3,
        StExec2  = 3'd4,
        StHalt   = 3'd7
    } state_e;

    localparam logic [3:0] OpNop = 4'h0;
    localparam logic [3:0] OpLda = 4'h1;
    localparam logic [3:0] OpAdd = 4'h2;
    localparam logic [3:0] OpSub = 4'h3;
    localparam logic [3:0] OpSta = 4'h4;
    localparam logic [3:0] OpLdi = 4'h5;
    localparam logic [3:0] OpJmp = 4'h6;
    localparam logic [3:0] OpJc  = 4'h7;
    localparam logic [3:0] OpJz  = 4'h8;
    localparam logic [3:0] OpOut = 4'hE;
    localparam logic [3:0] OpHlt = 4'hF;

    localparam int unsigned Depth = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_ram [Depth];

    state_e            r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_mar;
    // Only the opcode and operand fields of IR are kept; the bits between them are ignored.
    logic [3:0]        r_ir_op;
    logic [ADDR_W-1:0] r_ir_arg;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_out;
    logic              r_c;
    logic              r_z;
    logic              r_out_valid;

    logic [DATA_W-1:0] w_ram_rd;
    logic              w_is_sub;
    logic [DATA_W-1:0] w_b_op;
    logic [DATA_W:0]   w_sum;
    logic              w_sta_wr;

    // Combinational RAM read and ALU (SUB is A + ~B + 1, so carry set means no borrow).
    always_comb begin
        w_ram_rd = r_ram[r_mar];
        w_is_sub = (r_ir_op == OpSub);
        w_b_op   = w_is_sub ? ~r_b : r_b;
        w_sum    = {1'b0, r_a} + {1'b0, w_b_op} + (DATA_W + 1)'(w_is_sub);
        w_sta_wr = (r_state == StExec1) && (r_ir_op == OpSta);
    end

    // RAM write port: programmer owns it in program mode, otherwise STA writes A.
    always_ff @(posedge clk) begin
        if (pr_mode) begin
            if (pr_we) begin
                r_ram[pr_address] <= pr_data;
            end
        end else if (w_sta_wr) begin
            r_ram[r_mar] <= r_a;
        end
    end

    // Sequencer and datapath registers; program mode aborts and rewinds to address 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= StFetch0;
            r_pc        <= '0;
            r_mar       <= '0;
            r_ir_op     <= '0;
            r_ir_arg    <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_out       <= '0;
            r_c         <= 1'b0;
            r_z         <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (pr_mode) begin
            r_state     <= StFetch0;
            r_pc        <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                StFetch0: begin
                    r_mar   <= r_pc;
                    r_state <= StFetch1;
                end
                StFetch1: begin
                    r_ir_op  <= w_ram_rd[DATA_W-1 -: 4];
                    r_ir_arg <= w_ram_rd[ADDR_W-1:0];
                    r_pc     <= r_pc + ADDR_W'(1);
                    r_state  <= StExec0;
                end
                StExec0: begin
                    r_state <= StFetch0;
                    case (r_ir_op)
                        OpLda, OpAdd, OpSub, OpSta: begin
                            r_mar   <= r_ir_arg;
                            r_state <= StExec1;
                        end
                        OpLdi: r_a <= {{(DATA_W - ADDR_W){1'b0}}, r_ir_arg};
                        OpJmp: r_pc <= r_ir_arg;
                        OpJc:  if (r_c) r_pc <= r_ir_arg;
                        OpJz:  if (r_z) r_pc <= r_ir_arg;
                        OpOut: begin
                            r_out       <= r_a;
                            r_out_valid <= 1'b1;
                        end
                        OpHlt: r_state <= StHalt;
                        OpNop: ;
                        default: ;
                    endcase
                end
                StExec1: begin
                    r_state <= StFetch0;
                    case (r_ir_op)
                        OpLda: r_a <= w_ram_rd;
                        OpAdd, OpSub: begin
                            r_b     <= w_ram_rd;
                            r_state <= StExec2;
                        end
                        default: ;
                    endcase
                end
                StExec2: begin
                    r_a     <= w_sum[DATA_W-1:0];
                    r_c     <= w_sum[DATA_W];
                    r_z     <= (w_sum[DATA_W-1:0] == '0);
                    r_state <= StFetch0;
                end
                StHalt:  r_state <= StHalt;
                default: r_state <= StFetch0;
            endcase
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        out_data  = r_out;
        out_valid = r_out_valid;
        halted    = (r_state == StHalt);
        pc_dbg    = r_pc;
        step_dbg  = r_state;
    end

endmodule

// File: tb/tb_sap_core.sv
// Directed bench for sap_core (DATA_W=8, ADDR_W=4): small programs with hand-computed results.
module tb_sap_core;

    logic       clk;
    logic       rst;
    logic       pr_mode;
    logic       pr_we;
    logic [3:0] pr_address;
    logic [7:0] pr_data;
    logic [7:0] out_data;
    logic       out_valid;
    logic       halted;
    logic [3:0] pc_dbg;
    logic [2:0] step_dbg;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] prog [16];
    int         pulses;
    logic [7:0] last_out;

    sap_core #(
        .DATA_W(8),
        .ADDR_W(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pr_mode   (pr_mode),
        .pr_we     (pr_we),
        .pr_address(pr_address),
        .pr_data   (pr_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .halted    (halted),
        .pc_dbg    (pc_dbg),
        .step_dbg  (step_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 16; i++) prog[i] = 8'h00;
    endtask

    // Writes all 16 words through the programming port; leaves pr_mode low at a negedge.
    task automatic load_prog();
        @(negedge clk);
        pr_mode = 1'b1;
        for (int i = 0; i < 16; i++) begin
            pr_we      = 1'b1;
            pr_address = 4'(i);
            pr_data    = prog[i];
            @(negedge clk);
        end
        pr_we   = 1'b0;
        pr_mode = 1'b0;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic run_to_halt(input int max_cyc, output int np, output logic [7:0] lo);
        np = 0;
        lo = 8'h00;
        for (int i = 0; i < max_cyc && !halted; i++) begin
            @(negedge clk);
            if (out_valid) begin
                np++;
                lo = out_data;
            end
        end
        chk_eq("halt_reached", 32'(halted), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b0;
        pr_mode    = 1'b0;
        pr_we      = 1'b0;
        pr_address = 4'h0;
        pr_data    = 8'h00;
        #3;
        chk_eq("rst_step", 32'(step_dbg), 32'd0);
        chk_eq("rst_pc", 32'(pc_dbg), 32'd0);
        chk_eq("rst_out", 32'(out_data), 32'd0);
        chk_eq("rst_valid", 32'(out_valid), 32'd0);
        chk_eq("rst_halted", 32'(halted), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // LDA 14; ADD 15; OUT; HLT -> 28 + 14 = 42
        clear_prog();
        prog[0] = 8'h1E; prog[1] = 8'h2F; prog[2] = 8'hE0; prog[3] = 8'hF0;
        prog[14] = 8'd28; prog[15] = 8'd14;
        load_prog();
        run_to_halt(100, pulses, last_out);
        chk_eq("t1_out", 32'(last_out), 32'd42);
        chk_eq("t1_pulses", 32'(pulses), 32'd1);
        chk_eq("t1_out_data", 32'(out_data), 32'd42);
        chk_eq("t1_c", 32'(dut.r_c), 32'd0);
        chk_eq("t1_z", 32'(dut.r_z), 32'd0);
        chk_eq("t1_pc", 32'(pc_dbg), 32'd4);
        chk_eq("t1_step", 32'(step_dbg), 32'd7);
        // Programming writes outside program mode are dropped.
        pr_we = 1'b1; pr_address = 4'd14; pr_data = 8'h77;
        @(negedge clk);
        pr_we = 1'b0;
        chk_eq("t1_we_ignored", 32'(dut.r_ram[14]), 32'd28);
        chk_eq("t1_still_halted", 32'(halted), 32'd1);

        // LDI 5; STA 9; LDA 9; SUB 9; JZ 7; HLT ...; 7: OUT; HLT
        clear_prog();
        prog[0] = 8'h55; prog[1] = 8'h49; prog[2] = 8'h19; prog[3] = 8'h39;
        prog[4] = 8'h87; prog[5] = 8'hF0; prog[6] = 8'hF0;
        prog[7] = 8'hE0; prog[8] = 8'hF0;
        load_prog();
        chk_eq("t2_halt_cleared", 32'(halted), 32'd0);
        chk_eq("t2_out_kept", 32'(out_data), 32'd42);
        run_to_halt(100, pulses, last_out);
        chk_eq("t2_pulses", 32'(pulses), 32'd1);
        chk_eq("t2_out", 32'(out_data), 32'd0);
        chk_eq("t2_ram9", 32'(dut.r_ram[9]), 32'd5);
        chk_eq("t2_z", 32'(dut.r_z), 32'd1);
        chk_eq("t2_c", 32'(dut.r_c), 32'd1);
        chk_eq("t2_pc", 32'(pc_dbg), 32'd9);

        // LDA 14 (0xF0); ADD 15 (0x20); JC 0
        clear_prog();
        prog[0] = 8'h1E; prog[1] = 8'h2F; prog[2] = 8'h70;
        prog[14] = 8'hF0; prog[15] = 8'h20;
        load_prog();
        run_cycles(11);
        chk_eq("t3_pre_pc", 32'(pc_dbg), 32'd3);
        chk_eq("t3_pre_step", 32'(step_dbg), 32'd2);
        chk_eq("t3_a", 32'(dut.r_a), 32'h10);
        chk_eq("t3_c", 32'(dut.r_c), 32'd1);
        chk_eq("t3_z", 32'(dut.r_z), 32'd0);
        run_cycles(1);
        chk_eq("t3_jc_pc", 32'(pc_dbg), 32'd0);
        chk_eq("t3_jc_step", 32'(step_dbg), 32'd0);

        // JMP 15 at 0 and at 15: PC settles at 15 every FETCH0.
        clear_prog();
        prog[0] = 8'h6F; prog[15] = 8'h6F;
        load_prog();
        run_cycles(3);
        chk_eq("t4_jmp_pc", 32'(pc_dbg), 32'd15);
        run_cycles(2);
        chk_eq("t4_wrap_fetch", 32'(pc_dbg), 32'd0);
        run_cycles(1);
        chk_eq("t4_loop_pc", 32'(pc_dbg), 32'd15);
        // NOP at 15: PC wraps to 0 and stays there after EXEC0.
        prog[15] = 8'h00;
        load_prog();
        run_cycles(6);
        chk_eq("t4_nop_wrap", 32'(pc_dbg), 32'd0);
        chk_eq("t4_nop_step", 32'(step_dbg), 32'd0);

        // LDI 9; STA 12; HLT -- pr_mode pulse during STA EXEC1.
        clear_prog();
        prog[0] = 8'h59; prog[1] = 8'h4C; prog[2] = 8'hF0; prog[12] = 8'hAA;
        load_prog();
        run_cycles(6);
        chk_eq("t5_in_exec1", 32'(step_dbg), 32'd3);
        pr_mode = 1'b1;
        @(negedge clk);
        pr_mode = 1'b0;
        chk_eq("t5_ram_kept", 32'(dut.r_ram[12]), 32'hAA);
        chk_eq("t5_pc0", 32'(pc_dbg), 32'd0);
        chk_eq("t5_step0", 32'(step_dbg), 32'd0);
        run_cycles(2);
        chk_eq("t5_restart_pc", 32'(pc_dbg), 32'd1);
        run_to_halt(100, pulses, last_out);
        chk_eq("t5_ram_written", 32'(dut.r_ram[12]), 32'd9);

        // Reset asserted in the middle of ADD.
        clear_prog();
        prog[0] = 8'h1E; prog[1] = 8'h2F; prog[2] = 8'hE0; prog[3] = 8'hF0;
        prog[14] = 8'd28; prog[15] = 8'd14;
        load_prog();
        run_cycles(7);
        chk_eq("t6_pre_step", 32'(step_dbg), 32'd3);
        chk_eq("t6_pre_a", 32'(dut.r_a), 32'd28);
        chk_eq("t6_pre_c", 32'(dut.r_c), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk_eq("t6_a", 32'(dut.r_a), 32'd0);
        chk_eq("t6_b", 32'(dut.r_b), 32'd0);
        chk_eq("t6_c", 32'(dut.r_c), 32'd0);
        chk_eq("t6_pc", 32'(pc_dbg), 32'd0);
        chk_eq("t6_step", 32'(step_dbg), 32'd0);
        chk_eq("t6_ram", 32'(dut.r_ram[14]), 32'd28);
        @(negedge clk);
        rst = 1'b1;
        run_to_halt(100, pulses, last_out);
        chk_eq("t6_out", 32'(last_out), 32'd42);
        chk_eq("t6_pulses", 32'(pulses), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
